// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the writeback arbiter.
// Contents: word/register-address widths, the buffered writeback entry
// type, and the hard-wired zero register address.
package wb_arbiter_pkg;
    localparam int WORD_SIZE    = 32;
    localparam int REG_ADDR_LEN = 5;

    // Writes to r0 are architecturally discarded.
    localparam logic [REG_ADDR_LEN-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [REG_ADDR_LEN-1:0] dest;
        logic [WORD_SIZE-1:0]    val;
    } wb_entry_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the writeback arbiter and its surroundings.
// Signals:
//   prim_*     primary (ALU/load) result handshake
//   sec_*      secondary (mult/div) result handshake
//   wb_*       register file write port
//   pipe_stall stall request to the upstream pipeline
//   hz_*       hazard query addresses and pending-write flags
// Modports: slave = arbiter side, master = producer/consumer side.
interface wb_arbiter_if #(
    parameter int WORD_SIZE    = 32,
    parameter int REG_ADDR_LEN = 5
);
    logic                    prim_valid;
    logic                    prim_ready;
    logic [REG_ADDR_LEN-1:0] prim_dest;
    logic [WORD_SIZE-1:0]    prim_val;

    logic                    sec_valid;
    logic                    sec_ready;
    logic [REG_ADDR_LEN-1:0] sec_dest;
    logic [WORD_SIZE-1:0]    sec_val;

    logic                    wb_en;
    logic [REG_ADDR_LEN-1:0] wb_dest;
    logic [WORD_SIZE-1:0]    wb_val;
    logic                    pipe_stall;

    logic [REG_ADDR_LEN-1:0] hz_src1;
    logic [REG_ADDR_LEN-1:0] hz_src2;
    logic                    hz_busy1;
    logic                    hz_busy2;

    modport slave (
        input  prim_valid, prim_dest, prim_val,
        input  sec_valid, sec_dest, sec_val,
        input  hz_src1, hz_src2,
        output prim_ready, sec_ready,
        output wb_en, wb_dest, wb_val, pipe_stall,
        output hz_busy1, hz_busy2
    );

    modport master (
        output prim_valid, prim_dest, prim_val,
        output sec_valid, sec_dest, sec_val,
        output hz_src1, hz_src2,
        input  prim_ready, sec_ready,
        input  wb_en, wb_dest, wb_val, pipe_stall,
        input  hz_busy1, hz_busy2
    );
endinterface

// File: rtl/wb_fifo.sv
// Circular buffer for secondary writeback results.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push, din         enqueue request and entry (ignored when full)
//   pop, dout         dequeue request (ignored when empty), head entry
//   full, empty       occupancy flags
//   entry_vld         per-slot occupied flags
//   entry_dest        per-slot destination register, for hazard compare
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 push,
    input  logic                                 pop,
    input  wb_entry_t                            din,
    output wb_entry_t                            dout,
    output logic                                 full,
    output logic                                 empty,
    output logic [DEPTH-1:0]                     entry_vld,
    output logic [DEPTH-1:0][REG_ADDR_LEN-1:0]   entry_dest
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t         mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    for (genvar i = 0; i < DEPTH; i++) begin : g_dest
        assign entry_dest[i] = mem[i].dest;
    end

    // Storage needs no reset; entry_vld qualifies every slot.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // When both fire the FIFO is neither empty nor full, so the write and
    // read slots differ and the two entry_vld updates never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            entry_vld <= '0;
        end else begin
            if (do_push) begin
                wr_ptr            <= wr_ptr + 1'b1;
                entry_vld[wr_ptr] <= 1'b1;
            end
            if (do_pop) begin
                rd_ptr            <= rd_ptr + 1'b1;
                entry_vld[rd_ptr] <= 1'b0;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the single-cycle primary pipeline and the
// buffered multi-cycle secondary unit onto one register file write port.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus        wb_arbiter_if.slave: prim/sec handshakes, registered wb_*
//              write port, registered pipe_stall, combinational hazard
//              lookup (hz_src1/2 -> hz_busy1/2)
// Primary wins every cycle unless pipe_stall is up; pipe_stall is raised
// after STARVE_LIMIT consecutive primary wins over a non-empty FIFO.
// wb_entry_t fixes the FIFO entry width to the package constants, so the
// WORD_SIZE/REG_ADDR_LEN overrides must match them.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int WORD_SIZE    = wb_arbiter_pkg::WORD_SIZE,
    parameter int REG_ADDR_LEN = wb_arbiter_pkg::REG_ADDR_LEN,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] LIMIT = SC_W'(STARVE_LIMIT);

    logic                                      prim_xfer;
    logic                                      sec_xfer;
    logic                                      push;
    logic                                      pop;
    logic                                      full;
    logic                                      empty;
    wb_entry_t                                 sec_entry;
    wb_entry_t                                 head;
    logic [WORD_SIZE-1:0]                      head_val;
    logic [REG_ADDR_LEN-1:0]                   head_dest;
    logic [FIFO_DEPTH-1:0]                     entry_vld;
    logic [FIFO_DEPTH-1:0][REG_ADDR_LEN-1:0]   entry_dest;
    logic [SC_W-1:0]                           starve_cnt;
    logic [SC_W-1:0]                           starve_nxt;
    logic                                      hz1;
    logic                                      hz2;

    assign bus.prim_ready = !bus.pipe_stall;
    assign bus.sec_ready  = !full;
    assign prim_xfer      = bus.prim_valid && !bus.pipe_stall;
    assign sec_xfer       = bus.sec_valid && !full;
    // r0 results are acknowledged but never buffered.
    assign push           = sec_xfer && (bus.sec_dest != REG_ZERO);
    assign pop            = !prim_xfer && !empty;

    assign sec_entry = '{dest: bus.sec_dest, val: bus.sec_val};
    assign head_dest = head.dest;
    assign head_val  = head.val;

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .din        (sec_entry),
        .dout       (head),
        .full       (full),
        .empty      (empty),
        .entry_vld  (entry_vld),
        .entry_dest (entry_dest)
    );

    // Counts primary wins over a waiting FIFO head; saturates at LIMIT.
    always_comb begin
        starve_nxt = starve_cnt;
        if (pop || empty)
            starve_nxt = '0;
        else if (prim_xfer && starve_cnt != LIMIT)
            starve_nxt = starve_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.wb_en      <= 1'b0;
            bus.wb_dest    <= '0;
            bus.wb_val     <= '0;
            bus.pipe_stall <= 1'b0;
            starve_cnt     <= '0;
        end else begin
            starve_cnt     <= starve_nxt;
            // Raised the edge the counter lands on LIMIT, so the primary
            // wins exactly STARVE_LIMIT times before being held off.
            bus.pipe_stall <= (starve_nxt == LIMIT);
            if (prim_xfer) begin
                // An r0 primary still consumes the slot, as a bubble.
                bus.wb_en   <= (bus.prim_dest != REG_ZERO);
                bus.wb_dest <= bus.prim_dest;
                bus.wb_val  <= bus.prim_val;
            end else if (pop) begin
                bus.wb_en   <= 1'b1;
                bus.wb_dest <= head_dest;
                bus.wb_val  <= head_val;
            end else begin
                bus.wb_en   <= 1'b0;
            end
        end
    end

    // Pending writes: buffered entries plus the write on the port now.
    always_comb begin
        hz1 = bus.wb_en && (bus.wb_dest == bus.hz_src1);
        hz2 = bus.wb_en && (bus.wb_dest == bus.hz_src2);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            hz1 = hz1 || (entry_vld[i] && entry_dest[i] == bus.hz_src1);
            hz2 = hz2 || (entry_vld[i] && entry_dest[i] == bus.hz_src2);
        end
        bus.hz_busy1 = hz1 && (bus.hz_src1 != REG_ZERO);
        bus.hz_busy2 = hz2 && (bus.hz_src2 != REG_ZERO);
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized
// traffic, every cycle compared against a queue-based reference model.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int DEPTH = 4;
    localparam int LIMIT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_arbiter_if #(.WORD_SIZE(32), .REG_ADDR_LEN(5)) bus ();

    wb_arbiter #(
        .WORD_SIZE(32), .REG_ADDR_LEN(5), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // producer state: held until the model says the transfer happened
    logic        p_v = 0, s_v = 0;
    logic [4:0]  p_d = 0, s_d = 0;
    logic [31:0] p_val = 0, s_val = 0;
    logic [4:0]  h1 = 0, h2 = 0;
    int          sec_acc = 0;

    // reference model state
    wb_entry_t   mq[$];
    logic        m_en = 0, m_stall = 0;
    logic [4:0]  m_dest = 0;
    logic [31:0] m_val = 0;
    int          m_cnt = 0;

    wb_entry_t   wlog[$];   // writes observed on the DUT port

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_busy(input logic [4:0] s);
        if (s == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].dest == s) return 1'b1;
        return m_en && (m_dest == s);
    endfunction

    task automatic drive();
        bus.prim_valid = p_v; bus.prim_dest = p_d; bus.prim_val = p_val;
        bus.sec_valid  = s_v; bus.sec_dest  = s_d; bus.sec_val  = s_val;
        bus.hz_src1    = h1;  bus.hz_src2   = h2;
    endtask

    // One clock: check outputs against the model, then advance the model.
    task automatic step();
        logic px, sx, ne, pop;
        wb_entry_t e;
        @(negedge clk);
        rst = 1'b0;
        drive();
        #1;
        if (bus.wb_en) wlog.push_back('{dest: bus.wb_dest, val: bus.wb_val});
        chk("wb_en",      bus.wb_en,      m_en);
        chk("wb_dest",    bus.wb_dest,    m_dest);
        chk("wb_val",     bus.wb_val,     m_val);
        chk("pipe_stall", bus.pipe_stall, m_stall);
        chk("prim_ready", bus.prim_ready, !m_stall);
        chk("sec_ready",  bus.sec_ready,  mq.size() < DEPTH);
        chk("hz_busy1",   bus.hz_busy1,   m_busy(h1));
        chk("hz_busy2",   bus.hz_busy2,   m_busy(h2));

        px  = p_v && !m_stall;
        sx  = s_v && (mq.size() < DEPTH);
        ne  = (mq.size() != 0);
        pop = !px && ne;
        if (px) begin
            m_en = (p_d != 0); m_dest = p_d; m_val = p_val;
        end else if (pop) begin
            e = mq.pop_front();
            m_en = 1'b1; m_dest = e.dest; m_val = e.val;
        end else begin
            m_en = 1'b0;
        end
        if (pop || !ne)  m_cnt = 0;
        else if (px)     m_cnt = (m_cnt < LIMIT) ? m_cnt + 1 : m_cnt;
        m_stall = (m_cnt == LIMIT);
        if (sx && s_d != 0) mq.push_back('{dest: s_d, val: s_val});
        if (px) p_v = 1'b0;
        if (sx) begin s_v = 1'b0; sec_acc++; end
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        p_v = 1'b0; s_v = 1'b0;
        drive();
        @(posedge clk);
        mq.delete();
        m_en = 0; m_dest = 0; m_val = 0; m_stall = 0; m_cnt = 0;
    endtask

    task automatic offer_prim(input logic [4:0] d, input logic [31:0] v);
        p_v = 1'b1; p_d = d; p_val = v;
    endtask

    task automatic offer_sec(input logic [4:0] d, input logic [31:0] v);
        s_v = 1'b1; s_d = d; s_val = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int n;
        drive();
        do_reset();

        // reset state, hazard query on an idle register
        h1 = 5; h2 = 0;
        step();

        // primary only
        offer_prim(5'd3, 32'hDEADBEEF);
        step(); step();

        // secondary only, hazard visible while buffered and while writing
        h1 = 7;
        offer_sec(5'd7, 32'h1234);
        repeat (4) step();

        // contention: entry waits behind STARVE_LIMIT primary wins
        h1 = 9; h2 = 0;
        offer_sec(5'd9, 32'hAA);
        for (int i = 0; i < 8; i++) begin
            if (!p_v) offer_prim(5'(1 + i % 8), 32'h100 + i);
            step();
        end
        while (p_v) step();
        repeat (2) step();

        // full FIFO with continuous primary: order 1..5 preserved
        wlog.delete();
        sec_acc = 0;
        n = 0;
        for (int i = 0; i < 60 && sec_acc < 5; i++) begin
            if (!p_v) offer_prim(5'(1 + i % 10), 32'h1000 + i);
            if (!s_v && n < 5) begin offer_sec(5'(11 + n), 32'(n + 1)); n++; end
            step();
        end
        chk("full_accepted", sec_acc, 5);
        while (p_v) step();
        repeat (8) step();
        n = 0;
        foreach (wlog[i]) begin
            if (wlog[i].dest >= 11 && wlog[i].dest <= 15) begin
                chk("full_order_dest", wlog[i].dest, 11 + n);
                chk("full_order_val",  wlog[i].val,  n + 1);
                n++;
            end
        end
        chk("full_count", n, 5);

        // dest 0 secondary is dropped
        wlog.delete();
        offer_sec(5'd0, 32'hFF);
        repeat (3) step();
        n = 0;
        foreach (wlog[i]) if (wlog[i].val == 32'hFF) n++;
        chk("dest0_dropped", n, 0);

        // two entries buffered, then reset discards them
        offer_prim(5'd1, 32'h5000); offer_sec(5'd20, 32'h20);
        step();
        offer_prim(5'd2, 32'h5001); offer_sec(5'd21, 32'h21);
        step();
        chk("buffered_before_rst", mq.size(), 2);
        do_reset();
        wlog.delete();
        h1 = 20; h2 = 21;
        repeat (5) step();
        chk("no_wb_after_rst", wlog.size(), 0);

        // randomized traffic, small register range to provoke hazards/r0
        for (int i = 0; i < 500; i++) begin
            if (!p_v && $urandom_range(0, 2) != 0) offer_prim(5'($urandom_range(0, 7)), $urandom);
            if (!s_v && $urandom_range(0, 2) == 0) offer_sec(5'($urandom_range(0, 7)), $urandom);
            h1 = 5'($urandom_range(0, 7));
            h2 = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 99) == 0) do_reset();
            else step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
